// File: rtl/sample_fifo.sv
// Parametrised synchronous sample FIFO (any DEPTH >= 2) with occupancy, thresholds,
// sticky error flags and flush. Define SAMPLE_FIFO_FWFT_EN for first-word-fall-through reads.
module sample_fifo #(
    parameter  int DEPTH     = 16,
    parameter  int WIDTH     = 24,
    parameter  int AF_THRESH = DEPTH - 2,
    parameter  int AE_THRESH = 2,
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] write_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] read_data_o,
    input  logic             flush_i,
    input  logic             clear_err_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [LW-1:0]    level_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_set;
    logic             w_udf_set;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths use every entry.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status is decoded from the registered level only, never from the request inputs.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
    assign w_rd_acc  = !flush_i && rd_en_i && !w_empty;
    assign w_wr_acc  = !flush_i && wr_en_i && (!w_full || w_rd_acc);
    assign w_ovf_set = !flush_i && wr_en_i && !w_wr_acc;
    assign w_udf_set = !flush_i && rd_en_i && !w_rd_acc;

    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_rd_acc) r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_wr_acc && !w_rd_acc)
                r_level <= r_level + LW'(1);
            else if (!w_wr_acc && w_rd_acc)
                r_level <= r_level - LW'(1);
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; occupancy guards stale data.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= write_data_i;
    end

    // Set wins over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set)        r_overflow <= 1'b1;
            else if (clear_err_i) r_overflow <= 1'b0;
            if (w_udf_set)        r_underflow <= 1'b1;
            else if (clear_err_i) r_underflow <= 1'b0;
        end
    end

`ifdef SAMPLE_FIFO_FWFT_EN
    // Head entry is presented continuously; a pop just advances the read pointer.
    assign read_data_o = r_mem[r_rd_ptr];
`else
    logic [WIDTH-1:0] r_rd_data;

    // Read word holds between pops and across flush.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_rd_data <= '0;
        else if (w_rd_acc)
            r_rd_data <= r_mem[r_rd_ptr];
    end

    assign read_data_o = r_rd_data;
`endif

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_level >= LW'(AF_THRESH));
    assign almost_empty_o = (r_level <= LW'(AE_THRESH));
    assign level_o        = r_level;
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule
